imem_loader: RTL



---
 rtl/mips_pkg.sv | 14 +
 rtl/imem_word_packer.sv | 34 +++
 rtl/imem_loader.sv | 94 +++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS system: loader FSM states and the
// instruction-memory address width used by both loader and memory.
package mips_pkg;

  localparam int IMEM_ADDR_W = 6;

  typedef enum logic [1:0] {
    LEN_HI = 2'd0,
    LEN_LO = 2'd1,
    DATA   = 2'd2,
    DONE   = 2'd3
  } loader_state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Packs a byte stream MSB-first into 32-bit words; word_valid pulses
// combinationally on the cycle the 4th byte of a word is accepted.
module imem_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  in_byte,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt;
  logic [23:0] shreg;

  // Only the first three bytes need storing; the 4th is taken straight
  // from the input so the word is ready on the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= 2'd0;
      shreg <= 24'd0;
    end else if (clr) begin
      cnt   <= 2'd0;
      shreg <= 24'd0;
    end else if (en) begin
      cnt   <= cnt + 2'd1;
      shreg <= {shreg[15:0], in_byte};
    end
  end

  assign word_valid = en && (cnt == 2'd3);
  assign word       = {shreg, in_byte};

endmodule

// File: rtl/imem_loader.sv
// Streaming program loader: length-prefixed byte stream -> big-endian words
// written to instruction memory from address 0, then releases the core.
module imem_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_run,
  output logic              err,
  output loader_state_t     dbg_state
);

  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  // Handshake: a byte moves on any rising edge where in_valid & in_ready;
  // in_ready depends only on state, never on in_valid, and is high in
  // every state except DONE.
  loader_state_t state;
  logic [15:0]   n_words;
  logic [15:0]   word_idx;
  logic          xfer;
  logic          word_valid;
  logic [31:0]   word;

  assign in_ready  = (state != DONE);
  assign xfer      = in_valid && in_ready;
  assign dbg_state = state;

  imem_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        ((state == DONE) && reload),
    .en         (xfer && (state == DATA)),
    .in_byte    (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LEN_HI;
      n_words    <= 16'd0;
      word_idx   <= 16'd0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      cpu_run    <= 1'b0;
      err        <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        LEN_HI: if (xfer) begin
          n_words[15:8] <= in_data;
          state         <= LEN_LO;
        end
        LEN_LO: if (xfer) begin
          n_words[7:0] <= in_data;
          state        <= ({n_words[15:8], in_data} == 16'd0) ? DONE : DATA;
        end
        DATA: if (word_valid) begin
          // Words beyond memory depth are consumed silently and flagged.
          if ({1'b0, word_idx} < DEPTH) begin
            imem_we    <= 1'b1;
            imem_addr  <= word_idx[ADDR_W-1:0];
            imem_wdata <= word;
          end else begin
            err <= 1'b1;
          end
          word_idx <= word_idx + 16'd1;
          if (word_idx + 16'd1 == n_words) state <= DONE;
        end
        DONE: if (reload) begin
          cpu_run  <= 1'b0;
          word_idx <= 16'd0;
          err      <= 1'b0;
          state    <= LEN_HI;
        end else begin
          cpu_run <= 1'b1;
        end
        default: state <= LEN_HI;
      endcase
    end
  end

endmodule
